// File: rtl/rs232_defs.sv
// Shared RS-232 constants and receiver state encoding.
// The transmitter side imports the same line levels and default divisor.
package rs232_defs;

  localparam logic MARK      = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // 27 MHz clock cycles per bit; both link ends must agree on this value
  localparam int DEFAULT_DIVISOR = 352;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_MARK
  } rx_state_t;

endpackage

// File: rtl/rs232_sync2.sv
// Two-flop synchronizer for an asynchronous input.
// Both flops reset to mark, so a reset never looks like a start edge.
module rs232_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rs232receive.sv
// 8N1 serial receiver: validates the start bit at mid-bit and samples data LSB-first.
// Emits a one-cycle data_valid or framing_error strobe at the stop-bit sample.
module rs232receive
  import rs232_defs::*;
#(
  parameter int DIVISOR = DEFAULT_DIVISOR
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       framing_error,
  output logic       busy
);

  localparam int CW = $clog2(DIVISOR);
  localparam int H  = DIVISOR / 2;
  localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIVISOR - 1);

  rx_state_t     state;
  logic [CW-1:0] count;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          rxd_s;

  rs232_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rxd),
    .q     (rxd_s)
  );

  // The counter is cleared on every state change, so each sample point is an
  // exact offset from the synchronized start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      count         <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      data          <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
      case (state)
        IDLE: begin
          if (rxd_s == START_BIT) begin
            state <= START;
            count <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (count == HALF_LAST) begin
            count <= '0;
            if (rxd_s == START_BIT) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            count <= count + 1'b1;
          end
        end
        DATA: begin
          if (count == BIT_LAST) begin
            count <= '0;
            shift <= {rxd_s, shift[7:1]};
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            count <= count + 1'b1;
          end
        end
        STOP: begin
          if (count == BIT_LAST) begin
            count <= '0;
            if (rxd_s == STOP_BIT) begin
              data       <= shift;
              data_valid <= 1'b1;
              state      <= IDLE;
              busy       <= 1'b0;
            end else begin
              framing_error <= 1'b1;
              state         <= WAIT_MARK;
            end
          end else begin
            count <= count + 1'b1;
          end
        end
        // A break or stuck-low line must not be mistaken for a new start bit
        WAIT_MARK: begin
          if (rxd_s == MARK) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/rs232receive.md
# rs232receive

Serial receiver for the board's RS-232 link: the receive-side counterpart of the UART transmitter, running on the 27 MHz system clock at the same bit period. It synchronizes the asynchronous `rxd` pin, detects and validates start bits, samples 8 data bits LSB-first at mid-bit, and checks the stop bit. It delivers each byte with a one-cycle strobe to downstream logic (command parser / scan-control FSM).

## Interface
- `DIVISOR`, 352: clk cycles per bit; must equal the transmitter's value. Even, ≥ 8.
- `clk` input 1: 27 MHz system clock; all logic on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `rxd` input 1: serial line, idle = mark (1), asynchronous to `clk`.
- `data` output 8: last correctly framed byte; holds until the next good frame.
- `data_valid` output 1: one-cycle pulse when `data` is updated.
- `framing_error` output 1: one-cycle pulse when the stop bit samples 0.
- `busy` output 1: high whenever FSM is not IDLE.

## Operation
- Two-flop synchronizer `rxd` → `rxd_s`. Both flops reset to 1 (mark).
- Bit counter `count`, width ≥ clog2(`DIVISOR`); `H` = `DIVISOR`/2. Bit index 0–7.
- IDLE: on `rxd_s`==0, go to START with `count`=0.
- START: on `count`==`H`-1, sample `rxd_s`.
  - 0: go to DATA with `count`=0 and bit index 0.
  - 1: treat as a glitch and return to IDLE with no output.
- DATA: on `count`==`DIVISOR`-1, shift `rxd_s` into the MSB of the shift register (shift right), then `count`=0.
  - After bit index 7, go to STOP.
- STOP: on `count`==`DIVISOR`-1, sample `rxd_s`.
  - 1: load `data` from the shift register, pulse `data_valid`, go to IDLE.
  - 0: pulse `framing_error`, leave `data` unchanged, go to WAIT_MARK.
- WAIT_MARK: stay until `rxd_s`==1, then go to IDLE. This prevents a break or stuck-low line from retriggering frames.
- Counter wraps only via the explicit clears above; no free-running divider.
- Consecutive frames may arrive back to back (one stop bit). IDLE re-arms the cycle after the stop sample, so the next start edge is seen in time.
- Reset mid-frame: abort immediately with no pulses. Outputs return to reset values. FSM goes to IDLE and the synchronizer returns to 1.

## Timing
- Reset values: `data`=8'h00, `data_valid`=0, `framing_error`=0, `busy`=0, FSM=IDLE, `count`=0.
- Edge 0 is the first rising edge at which the `rxd` pin is low.
  - FSM enters START at edge 2.
  - Start sample at edge `H`+2.
  - Data bit k sampled at edge `H`+2+(k+1)·`DIVISOR`.
  - Stop sample at edge `H`+2+9·`DIVISOR`.
- `data_valid` / `framing_error` are registered at the stop-sample edge and high for exactly the following cycle. `data` changes at the same edge.
- `DIVISOR`=352: `data_valid` asserts after edge 3346. `DIVISOR`=16: after edge 154.
- Minimum start-low width to be accepted: > `H` cycles. Shorter pulses return to IDLE at edge `H`+2.
- `data_valid` and `framing_error` are never high in the same cycle.

## Structure
- Shared package/header `rs232_defs`:
  - `MARK`, `START_BIT`, `STOP_BIT` constants.
  - Default `DIVISOR`.
  - FSM state encoding: IDLE, START, DATA, STOP, WAIT_MARK.
  - The transmitter uses the same constants.
- Sub-module `rs232_sync2`: two-flop synchronizer with async reset to 1. Reusable for other async inputs.
- Everything else in one always block for the FSM/counter plus an output register block.

## Test plan
- `DIVISOR`=16, send 0x55 (8N1) → `data`=0x55, `data_valid` high only after edge 154, `framing_error` never high.
- Back-to-back 0xA3 then 0x0F with single stop bits → two `data_valid` pulses, 160 cycles apart, values 0xA3 then 0x0F.
- `rxd` low for 3 cycles then high → `busy` pulses, returns to IDLE, no `data_valid`/`framing_error`, `data` unchanged.
- Frame 0x12 with stop bit forced 0, then line held low 100 cycles → one `framing_error` pulse, `data` keeps its previous value, no further frames until the line returns high.
- Assert `reset` during bit 4 of a frame → all outputs at reset values immediately. Next clean 0x7E frame is received correctly.
- Loopback from the UART transmitter, both at `DIVISOR`=352, sending 0x41 → `data`=0x41, single `data_valid`, `framing_error`=0.
